// File: rtl/btn_scan_debounce_if.sv
// rtl/btn_scan_debounce_if.sv - pad, mode and debounced-status signals of the button scanner
// master: scanner side; slave: pad tristate / LED side.
interface btn_scan_debounce_if #(
  parameter int N = 4
);
  logic [N-1:0] btn_oe;
  logic [N-1:0] btn_in;
  logic [N-1:0] mode;
  logic         sample_strobe;
  logic [N-1:0] pressed;
  logic [N-1:0] press_pulse;
  logic [N-1:0] release_pulse;
  logic [N-1:0] led;

  modport master (
    output btn_oe, sample_strobe, pressed, press_pulse, release_pulse, led,
    input  btn_in, mode
  );

  modport slave (
    input  btn_oe, sample_strobe, pressed, press_pulse, release_pulse, led,
    output btn_in, mode
  );
endinterface

// File: rtl/btn_scan_debounce.sv
// rtl/btn_scan_debounce.sv - discharge/settle/sample pad scanner with per-channel debounce and LED drive
// All channels share one scan sequencer; debounce state is kept independently per channel.
module btn_scan_debounce #(
  parameter int N             = 4,
  parameter int DISCHARGE_CYC = 16,
  parameter int SETTLE_CYC    = 64,
  parameter int DEB_SCANS     = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  btn_scan_debounce_if.master    bus
);

  localparam int P  = DISCHARGE_CYC + SETTLE_CYC + 1;
  localparam int KW = $clog2(P);
  localparam int CW = $clog2(DEB_SCANS + 1);

  localparam logic [KW-1:0] K_DIS_LAST = KW'(DISCHARGE_CYC - 1);
  localparam logic [KW-1:0] K_SET_LAST = KW'(P - 2);
  localparam logic [CW-1:0] CNT_MAX    = CW'(DEB_SCANS - 1);

  typedef enum logic [1:0] {
    PH_DISCHARGE = 2'd0,
    PH_SETTLE    = 2'd1,
    PH_SAMPLE    = 2'd2
  } phase_e;

  phase_e        phase_q, phase_d;
  logic [KW-1:0] k_q, k_d;
  logic [N-1:0]  oe_q, oe_d;
  logic          strobe_q, strobe_d;

  logic [N-1:0]  pressed_q, pressed_d;
  logic [N-1:0]  press_q, press_d;
  logic [N-1:0]  rel_q, rel_d;
  logic [N-1:0]  led_q, led_d;
  logic [CW-1:0] cnt_q [N];
  logic [CW-1:0] cnt_d [N];

  // Pad drive and strobe are decoded from the next phase so they are registered and line up with k.
  always_comb begin
    phase_d = phase_q;
    k_d     = k_q + 1'b1;
    case (phase_q)
      PH_DISCHARGE: if (k_q == K_DIS_LAST) phase_d = PH_SETTLE;
      PH_SETTLE:    if (k_q == K_SET_LAST) phase_d = PH_SAMPLE;
      PH_SAMPLE: begin
        phase_d = PH_DISCHARGE;
        k_d     = '0;
      end
      default: begin
        phase_d = PH_DISCHARGE;
        k_d     = '0;
      end
    endcase
    oe_d     = (phase_d == PH_DISCHARGE) ? {N{1'b1}} : {N{1'b0}};
    strobe_d = (phase_d == PH_SAMPLE);
  end

  always_comb begin
    pressed_d = pressed_q;
    led_d     = led_q;
    press_d   = '0;
    rel_d     = '0;
    cnt_d     = cnt_q;
    if (strobe_q) begin
      for (int i = 0; i < N; i++) begin
        if ((~bus.btn_in[i]) == pressed_q[i]) begin
          cnt_d[i] = '0;
        end else if (cnt_q[i] == CNT_MAX) begin
          cnt_d[i]     = '0;
          pressed_d[i] = ~pressed_q[i];
          press_d[i]   = ~pressed_q[i];
          rel_d[i]     = pressed_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
        if (bus.mode[i]) begin
          led_d[i] = pressed_d[i];
        end else if (press_d[i]) begin
          led_d[i] = ~led_q[i];
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase_q   <= PH_DISCHARGE;
      k_q       <= '0;
      oe_q      <= {N{1'b1}};
      strobe_q  <= 1'b0;
      pressed_q <= '0;
      press_q   <= '0;
      rel_q     <= '0;
      led_q     <= '0;
      cnt_q     <= '{default: '0};
    end else begin
      phase_q   <= phase_d;
      k_q       <= k_d;
      oe_q      <= oe_d;
      strobe_q  <= strobe_d;
      pressed_q <= pressed_d;
      press_q   <= press_d;
      rel_q     <= rel_d;
      led_q     <= led_d;
      cnt_q     <= cnt_d;
    end
  end

  assign bus.btn_oe        = oe_q;
  assign bus.sample_strobe = strobe_q;
  assign bus.pressed       = pressed_q;
  assign bus.press_pulse   = press_q;
  assign bus.release_pulse = rel_q;
  assign bus.led           = led_q;

endmodule

// File: doc/btn_scan_debounce.md
# btn_scan_debounce

Parametrised scanner and debouncer for the iCEblink40-LP1K capacitive-style button pads, generalised to `N` channels. Each scan runs three phases:

- Discharge: drives all pads low.
- Settle: releases the pads.
- Sample: samples all pads in one cycle.

Each channel is then debounced over consecutive scans, and the block generates press/release pulses and an LED drive per channel in toggle or follow mode. It sits between the top-level `inout` pad tristates and the LED outputs. All channels update independently in the same cycle, with no priority chain.

## Interface
- `N`, default 4: number of button/LED channels (≥1).
- `DISCHARGE_CYC`, default 16: clock cycles pads are driven low per scan (≥1).
- `SETTLE_CYC`, default 64: clock cycles pads are released before sampling (≥1).
- `DEB_SCANS`, default 4: consecutive disagreeing samples needed to flip a debounced state (≥1).

- `clk` in 1: system clock.
- `rst` in 1: asynchronous, active-high reset.
- `btn_oe` out N: pad drive-low enable. The top level drives the pad to 0 when 1 and to Z when 0.
- `btn_in` in N: pad input value. Pad reads 0 at sample = pressed.
- `mode` in N: per-channel LED mode. 0 = toggle on press, 1 = follow debounced level.
- `sample_strobe` out 1: high during the SAMPLE cycle.
- `pressed` out N: debounced pressed state.
- `press_pulse` out N: one-cycle pulse when `pressed[i]` rises.
- `release_pulse` out N: one-cycle pulse when `pressed[i]` falls.
- `led` out N: LED drive, 1 = on.

## Operation
- **Scan period** is P = DISCHARGE_CYC + SETTLE_CYC + 1 cycles. Phase counter k runs 0..P−1 and wraps to 0.
- **Scan phases:**
  - DISCHARGE, k in [0, DISCHARGE_CYC−1]: `btn_oe` = all ones.
  - SETTLE, k in [DISCHARGE_CYC, DISCHARGE_CYC+SETTLE_CYC−1]: `btn_oe` = all zeros.
  - SAMPLE, k = P−1: `btn_oe` = all zeros and `sample_strobe` = 1.
- **Raw sample:** raw[i] = ~btn_in[i], evaluated at the clock edge that ends the SAMPLE cycle. `btn_in` is ignored in every other cycle.
- **Debounce, per channel.** Counter `cnt[i]` has width clog2(DEB_SCANS+1). At each sample edge:
  - If raw == `pressed[i]`: cnt ← 0.
  - Else if cnt == DEB_SCANS−1: `pressed[i]` flips, cnt ← 0, and the matching pulse fires.
  - Else: cnt ← cnt+1.
  - A single agreeing sample resets the count, so isolated glitches never propagate.
- **Pulses:** `press_pulse[i]` / `release_pulse[i]` are high for exactly the one cycle after the flipping edge. They are never both high, and never high outside the cycle after a SAMPLE edge.
- **LED:**
  - `mode[i]` = 0: `led[i]` toggles on the same edge where `press_pulse[i]` is generated. It is unchanged on release.
  - `mode[i]` = 1: `led[i]` ← new `pressed[i]` at every sample edge.
  - `mode` is read only at sample edges. A mode change alone never alters `led`.
  - Switching 1→0 holds the current `led` value.
- **Reset (async):**
  - k = 0, `btn_oe` = all ones, `sample_strobe` = 0, `pressed` = 0, pulses = 0, `led` = 0, all cnt = 0.
  - Assertion mid-scan aborts immediately. After deassertion the scan restarts at DISCHARGE, k = 0.

## Timing
- `btn_oe` and `sample_strobe` are registered outputs decoded from k, with no combinational path from inputs.
- `pressed`, pulses and `led` change only on the edge ending SAMPLE, becoming visible at k = 0 of the next scan.
- **Minimum press-detection latency:** DEB_SCANS sample edges after the first pressed sample, i.e. (DEB_SCANS−1)·P + 1 cycles after that SAMPLE cycle begins.
- **Release latency:** identical to press latency.
- With defaults, P = 81 and the sample edge occurs at cycles 80, 161, 242, … after reset release.
- **Throughput:** at most one debounced transition per channel per DEB_SCANS scans. All N channels may transition on the same edge.

## Test plan
1. **Reset / idle.** Hold `btn_in` = all ones for 10 scans with defaults. Required response:
   - `btn_oe` = 1111 for cycles 0–15 and 0000 for cycles 16–80 of each scan.
   - `sample_strobe` high only at k = 80.
   - `pressed` = 0, `led` = 0, no pulses.
2. **Debounced press, toggle mode.** `mode` = 0000; `btn_in[0]` = 0 from scan 2 onward. Required response:
   - `pressed[0]` rises after the 4th low sample (edge ending cycle 2·81 + 3·81 + 80).
   - `press_pulse[0]` high exactly 1 cycle.
   - `led[0]` = 1.
   - A second press→release→press cycle returns `led[0]` to 0 then back to 1.
3. **Glitch rejection.** `btn_in[1]` low for 3 scans, high for 1, low for 3. Required response: `pressed[1]` stays 0 and no pulses.
4. **Follow mode and simultaneity.** `mode` = 1111; all four pads low for 4 scans, then high for 4 scans. Required response:
   - `pressed` = 1111 and `led` = 1111 with 4 `press_pulse` bits on the same cycle.
   - Later `release_pulse` = 1111 with `led` = 0000.
5. **Mode switch.** Channel 2 in follow mode, held pressed (`led[2]` = 1); switch `mode[2]` to 0. Required response: `led[2]` holds 1, and the next release/press toggles `led[2]` to 0.
6. **Reset mid-operation.** Assert `rst` at k = 40 with cnt[0] = 2. Required response:
   - All outputs immediately at their reset values.
   - After release, `btn_oe` = 1111 for 16 cycles.
   - The debounce count restarts, so 4 fresh low samples are needed.
   - N = 1 and N = 8 builds also pass scenario 2.
